// File: rtl/mips_pkg.sv
// Shared MIPS definitions: NOP encoding, primary opcodes and the fetch-stage state type.
package mips_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;  // sll $0,$0,0

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;

  typedef enum logic [1:0] {
    S_START,
    S_FETCH,
    S_HOLD
  } ifetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter: synchronous reset, redirect mux with word alignment, +4 increment on load.
module pc_reg #(
  parameter logic [31:0] ResetPc = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic [31:0] pc_q, pc_d;

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + 32'd4;

  // Redirect outranks sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = target_i & 32'hFFFF_FFFC;
    end else if (load_i) begin
      pc_d = pc_plus4_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage with IF/ID register, stall skid buffer and branch redirect.
// Define IFETCH_DELAY_SLOT_EN to deliver the in-flight word as a branch delay slot.
module ifetch_stage import mips_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [5:0]  opcode
);

`ifdef IFETCH_DELAY_SLOT_EN
  localparam bit KeepSlot = 1'b1;
`else
  localparam bit KeepSlot = 1'b0;
`endif

  ifetch_state_e state_q, state_d;

  logic [31:0] pc, pc_plus4;
  logic        pc_load;

  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        redirect_pend_q, redirect_pend_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_pc4_q, req_pc4_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        skid_adv_q, skid_adv_d;

  logic        slot_ack;
  logic [31:0] fetch_pc4;

  pc_reg #(
    .ResetPc(RESET_PC)
  ) u_pc_reg (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (pc_load),
    .redirect_i(branch_taken),
    .target_i  (branch_target),
    .pc_o      (pc),
    .pc_plus4_o(pc_plus4)
  );

  // An ack is the redirect's slot word when the branch arrives with it or is already pending.
  assign slot_ack  = (state_q == S_FETCH) && imem_ack && (branch_taken || redirect_pend_q);
  assign fetch_pc4 = redirect_pend_q ? req_pc4_q : pc_plus4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_START;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack && stall && !branch_taken && (!redirect_pend_q || KeepSlot)) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (branch_taken || !stall) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_START;
    endcase
  end

  // Request address is frozen at the old PC while a redirect waits for its ack.
  always_comb begin
    imem_req  = (state_q == S_FETCH) && !rst;
    imem_addr = redirect_pend_q ? req_addr_q : pc;
  end

  always_comb begin
    ifid_instr_d    = ifid_instr_q;
    ifid_pc4_d      = ifid_pc4_q;
    ifid_valid_d    = ifid_valid_q;
    redirect_pend_d = redirect_pend_q;
    req_addr_d      = req_addr_q;
    req_pc4_d       = req_pc4_q;
    skid_d          = skid_q;
    skid_pc4_d      = skid_pc4_q;
    skid_adv_d      = skid_adv_q;
    pc_load         = 1'b0;
    unique case (state_q)
      S_START: begin
        if (branch_taken) begin
          ifid_instr_d = NOP_WORD;
          ifid_valid_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (slot_ack) begin
          redirect_pend_d = 1'b0;
          if (KeepSlot && stall && !branch_taken) begin
            skid_d     = imem_rdata;
            skid_pc4_d = fetch_pc4;
            skid_adv_d = 1'b0;
          end else if (KeepSlot) begin
            ifid_instr_d = imem_rdata;
            ifid_pc4_d   = fetch_pc4;
            ifid_valid_d = 1'b1;
          end else if (!stall || branch_taken) begin
            ifid_instr_d = NOP_WORD;
            ifid_valid_d = 1'b0;
          end
        end else if (imem_ack && stall) begin
          skid_d     = imem_rdata;
          skid_pc4_d = pc_plus4;
          skid_adv_d = 1'b1;
        end else if (imem_ack) begin
          ifid_instr_d = imem_rdata;
          ifid_pc4_d   = pc_plus4;
          ifid_valid_d = 1'b1;
          pc_load      = 1'b1;
        end else if (branch_taken) begin
          ifid_instr_d = NOP_WORD;
          ifid_valid_d = 1'b0;
          if (!redirect_pend_q) begin
            redirect_pend_d = 1'b1;
            req_addr_d      = pc;
            req_pc4_d       = pc_plus4;
          end
        end else if (!stall) begin
          ifid_instr_d = NOP_WORD;
          ifid_valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (branch_taken && !KeepSlot) begin
          ifid_instr_d = NOP_WORD;
          ifid_valid_d = 1'b0;
        end else if (branch_taken || !stall) begin
          ifid_instr_d = skid_q;
          ifid_pc4_d   = skid_pc4_q;
          ifid_valid_d = 1'b1;
          pc_load      = skid_adv_q && !branch_taken;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_instr_q    <= NOP_WORD;
      ifid_pc4_q      <= 32'h0;
      ifid_valid_q    <= 1'b0;
      redirect_pend_q <= 1'b0;
      req_addr_q      <= 32'h0;
      req_pc4_q       <= 32'h0;
      skid_q          <= NOP_WORD;
      skid_pc4_q      <= 32'h0;
      skid_adv_q      <= 1'b0;
    end else begin
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc4_q      <= ifid_pc4_d;
      ifid_valid_q    <= ifid_valid_d;
      redirect_pend_q <= redirect_pend_d;
      req_addr_q      <= req_addr_d;
      req_pc4_q       <= req_pc4_d;
      skid_q          <= skid_d;
      skid_pc4_q      <= skid_pc4_d;
      skid_adv_q      <= skid_adv_d;
    end
  end

  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_valid = ifid_valid_q;
  assign opcode     = ifid_instr_q[31:26];

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: transaction-level fetch model checked every cycle,
// plus literal expectations; a second instance covers RESET_PC wrap-around.
module tb_ifetch_stage;

`ifdef IFETCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_HELD = 2;

  logic        clk = 1'b0;
  logic        rst, imem_ack, stall, branch_taken;
  logic [31:0] imem_rdata, branch_target;
  logic        imem_req, ifid_valid;
  logic [31:0] imem_addr, ifid_instr, ifid_pc4;
  logic [5:0]  opcode;
  logic        d2_req, d2_valid;
  logic [31:0] d2_addr, d2_instr, d2_pc4;
  logic [5:0]  d2_opcode;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  ifetch_stage dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .opcode(opcode)
  );

  ifetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .imem_req(d2_req), .imem_addr(d2_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .ifid_instr(d2_instr), .ifid_pc4(d2_pc4),
    .ifid_valid(d2_valid), .opcode(d2_opcode)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Model: m_addr is the address the current (or next) request carries; a redirect that
  // arrives mid-request is remembered in m_tgt and applied once that request completes.
  int          m_phase;
  logic [31:0] m_addr, m_tgt, m_held_word, m_held_addr;
  logic [31:0] m_ifid_instr, m_ifid_pc4;
  bit          m_tgt_pend, m_held_slot, m_ifid_valid;

  task automatic m_deliver(input logic [31:0] w, input logic [31:0] a);
    m_ifid_instr = w;
    m_ifid_pc4   = a + 32'd4;
    m_ifid_valid = 1'b1;
  endtask

  task automatic m_bubble();
    m_ifid_instr = NOP;
    m_ifid_valid = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] tgt, nxt;
    tgt = branch_target & 32'hFFFF_FFFC;
    if (rst) begin
      m_phase = PH_IDLE; m_addr = 32'h0; m_tgt_pend = 1'b0;
      m_ifid_instr = NOP; m_ifid_pc4 = 32'h0; m_ifid_valid = 1'b0;
    end else if (m_phase == PH_IDLE) begin
      if (branch_taken) begin
        m_addr = tgt;
        m_bubble();
      end
      m_phase = PH_REQ;
    end else if (m_phase == PH_REQ) begin
      if (imem_ack && (branch_taken || m_tgt_pend)) begin
        nxt = branch_taken ? tgt : m_tgt;
        if (DS && stall && !branch_taken) begin
          m_held_word = imem_rdata; m_held_addr = m_addr; m_held_slot = 1'b1;
          m_phase = PH_HELD;
        end else if (DS) m_deliver(imem_rdata, m_addr);
        else if (!stall || branch_taken) m_bubble();
        m_addr = nxt;
        m_tgt_pend = 1'b0;
      end else if (imem_ack && stall) begin
        m_held_word = imem_rdata; m_held_addr = m_addr; m_held_slot = 1'b0;
        m_phase = PH_HELD;
      end else if (imem_ack) begin
        m_deliver(imem_rdata, m_addr);
        m_addr = m_addr + 32'd4;
      end else if (branch_taken) begin
        m_tgt_pend = 1'b1;
        m_tgt = tgt;
        m_bubble();
      end else if (!stall) m_bubble();
    end else if (branch_taken || !stall) begin
      if (branch_taken && !DS) m_bubble();
      else m_deliver(m_held_word, m_held_addr);
      if (branch_taken) m_addr = tgt;
      else if (!m_held_slot) m_addr = m_held_addr + 32'd4;
      m_phase = PH_REQ;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      logic exp_req;
      exp_req = (m_phase == PH_REQ) && !rst;
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr, m_addr);
      chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_ifid_valid});
      chk("ifid_instr", ifid_instr, m_ifid_instr);
      chk("ifid_pc4", ifid_pc4, m_ifid_pc4);
      chk("opcode", {26'b0, opcode}, {26'b0, m_ifid_instr[31:26]});
    end
  end

  task automatic drive(input bit r, input bit a, input logic [31:0] d, input bit s,
                       input bit b, input logic [31:0] t);
    rst = r; imem_ack = a; imem_rdata = d; stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
    chk("rst_pc4", ifid_pc4, 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    chk("start_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("wrap_first_addr", d2_addr, 32'hFFFF_FFFC);
    drive(0, 1, 32'h8C01_0004, 0, 0, 0);
    chk("lw_instr", ifid_instr, 32'h8C01_0004);
    chk("lw_opcode", {26'b0, opcode}, 32'h23);
    chk("lw_pc4", ifid_pc4, 32'h4);
    chk("addr_4", imem_addr, 32'h4);
    chk("wrap_pc4", d2_pc4, 32'h0);
    chk("wrap_second_addr", d2_addr, 32'h0);
    drive(0, 1, 32'h0022_1820, 0, 0, 0);
    chk("add_opcode", {26'b0, opcode}, 32'h00);
    chk("add_pc4", ifid_pc4, 32'h8);
    chk("addr_8", imem_addr, 32'h8);
    drive(0, 1, 32'h2001_0005, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      chk("stall_hold", ifid_instr, 32'h0022_1820);
      if (i < 2) drive(0, 0, 0, 1, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("skid_instr", ifid_instr, 32'h2001_0005);
    chk("skid_pc4", ifid_pc4, 32'hC);
    chk("addr_c", imem_addr, 32'hC);
    drive(0, 0, 0, 0, 1, 32'h40);
    chk("redir_addr_hold0", imem_addr, 32'hC);
    drive(0, 0, 0, 0, 0, 0);
    chk("redir_addr_hold1", imem_addr, 32'hC);
    drive(0, 1, 32'hAC22_0008, 0, 0, 0);
    chk("slot_valid", {31'b0, ifid_valid}, {31'b0, DS});
    chk("target_addr", imem_addr, 32'h40);
    drive(0, 1, 32'h8C03_0000, 0, 0, 0);
    chk("target_pc4", ifid_pc4, 32'h44);
    drive(0, 1, 32'h0000_0020, 1, 1, 32'h101);
    chk("stall_branch_req", {31'b0, imem_req}, 32'd1);
    chk("stall_branch_addr", imem_addr, 32'h100);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("midrst_instr", ifid_instr, 32'h0);
    chk("midrst_valid", {31'b0, ifid_valid}, 32'd0);
    drive(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("late_ack_instr", ifid_instr, 32'h0);
    chk("late_ack_pc4", ifid_pc4, 32'h0);
    chk("late_ack_addr", imem_addr, 32'h0);
    drive(0, 1, 32'h8C01_0004, 0, 0, 0);
    drive(0, 1, 32'h1022_0003, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 32'h80);
    drive(0, 1, 32'h2002_0007, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h200);
    drive(0, 1, 32'hAC05_0010, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h0085_3020, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
